gf180mcu_osu_sc_12t_cgctl_1: RTL and testbench
==============================================

# gf180mcu_osu_sc_12T_cgctl_1

Clock-gate enable controller for the 12T library. It produces a glitch-free enable `EN` that drives input B of the downstream `and2` gating cell, with `Y = CLK & EN` as the gated clock. Consumers request the gated clock with a REQ/ACK handshake. The block runs a settle period before acknowledging, keeps the clock alive while the gated domain reports activity, and shuts the clock off after a programmable idle timeout.

## Interface
- `WAKE_CYCLES`, default 2: cycles spent in WAKE before ACK; must be ≥1.
- `IDLE_CYCLES`, default 16: consecutive idle cycles in DRAIN before shut-off; must be ≥1.
- `CW`, default 8: counter width; both cycle parameters must be ≤ 2^CW.
- `CLK` in, 1: single clock; every flop uses this clock.
- `RN` in, 1: reset, synchronous, active-low, sampled on the rising edge of CLK.
- `REQ` in, 1: consumer request for the gated clock (level).
- `BUSY` in, 1: activity flag from the gated domain; keeps the clock alive.
- `FORCE` in, 1: test override; behaves as REQ and also freezes the idle countdown.
- `ACK` out, 1: gated clock is stable and granted.
- `EN` out, 1: gate enable to the downstream and2 B input; changes only while CLK is low.
- `STATE` out, 2: FSM state encoding (OFF=00, WAKE=01, ON=10, DRAIN=11).

## Operation
- FSM state register and down-counter `cnt[CW-1:0]` update on the CLK rising edge.
- A counter load value of N means "load N-1". A state that loads N therefore occupies exactly N cycles: if `cnt==0`, exit; otherwise decrement.
- **OFF**
  - REQ|FORCE → WAKE, load WAKE_CYCLES.
  - BUSY is ignored.
- **WAKE**
  - Always runs to completion; REQ and BUSY are ignored.
  - When `cnt==0` → ON.
- **ON**
  - If !REQ & !BUSY & !FORCE → DRAIN, load IDLE_CYCLES.
  - Otherwise stay in ON.
- **DRAIN**, evaluated in priority order:
  1. REQ|FORCE → ON; no new WAKE is required.
  2. BUSY → reload IDLE_CYCLES and stay in DRAIN.
  3. `cnt==0` → OFF.
  4. Otherwise decrement.
- `ACK` = (STATE==ON), decoded from the registered state, so it has no combinational path from any input.
- Internal `en_q` = (STATE≠OFF).
- `EN` is `en_q` re-sampled on the CLK falling edge. EN therefore transitions only in the CLK-low phase, and `CLK & EN` never produces a runt pulse.
- Simultaneous events:
  - DRAIN with `cnt==0` and REQ=1 → ON (REQ wins); EN stays high continuously.
  - DRAIN with BUSY=1 and `cnt==0` → reload (BUSY wins over expiry).
- The idle countdown requires IDLE_CYCLES consecutive cycles with REQ=BUSY=FORCE=0.

## Timing
- Reset
  - RN=0 at rising edge r → STATE=00, `cnt`=0, ACK=0 after edge r.
  - EN=0 from falling edge r+½.
  - Output values before the first reset edge are undefined.
- Reset mid-operation
  - Same as reset: EN falls at the next falling edge.
  - The last gated pulse on Y is the complete pulse that started at edge r.
- Wake latency
  - REQ sampled high at edge k (STATE=OFF) → STATE=WAKE after edge k.
  - EN rises at k+½, so the first gated rising edge occurs at k+1.
  - ACK=1 and STATE=ON after edge k+WAKE_CYCLES.
- Shut-off
  - Idle condition sampled at edge t in ON → DRAIN after t.
  - With no activity, STATE=OFF after edge t+IDLE_CYCLES and EN falls at t+IDLE_CYCLES+½.
  - Y delivers gated pulses at edges t+1 … t+IDLE_CYCLES.
- ACK drops on the same edge that enters DRAIN.
- DRAIN→ON: ACK re-asserts one edge after the request is sampled.

## Test plan
- Reset: hold RN=0 for 2 cycles with REQ=1 → STATE=00, ACK=0, EN=0 from the first falling edge. Release RN → STATE=01 after the next rising edge.
- Wake (WAKE_CYCLES=2): REQ↑ sampled at edge 0 → STATE=01 after edge 0, EN↑ at 0.5, STATE=10 and ACK=1 after edge 2. Y shows pulses at edges 1 and 2.
- Drain (IDLE_CYCLES=4): drop REQ before edge 10 → STATE=11 after 10, ACK=0, STATE=00 after 14, EN↓ at 14.5. Exactly 4 Y pulses (edges 11–14), none at 15.
- BUSY reload: in DRAIN, BUSY=1 for one cycle sampled at edge 12 → OFF occurs after edge 16, not 14. With FORCE=1 held in ON, the block never leaves ON.
- Late re-request: REQ=1 sampled at the DRAIN edge where `cnt==0` → STATE=10 next, ACK=1, EN never deasserts. The gated clock on Y is continuous with no missing or runt pulse.
- Reset mid-ON: RN=0 sampled at edge 20 → STATE=00 and ACK=0 after 20, EN↓ at 20.5. Y high time at edge 20 is a full half-period; no pulse at edge 21.

Source files
------------

// File: rtl/gf180mcu_osu_sc_12t_cgctl_1.sv
// Clock-gate enable controller for the 12T and2 gating cell.
// A consumer requests the gated clock with a REQ/ACK handshake. The block
// runs a wake settle period before acknowledging, keeps the clock alive
// while BUSY is high, and shuts the clock off after an idle timeout.
// EN is re-timed on the falling edge, so CLK & EN never produces a runt pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// OFF   | gated clock stopped, EN low, waiting for REQ or FORCE
// WAKE  | EN high, clock settling for WAKE_CYCLES, ACK still low
// ON    | clock granted, ACK high
// DRAIN | no request or activity, counting IDLE_CYCLES toward OFF
module gf180mcu_osu_sc_12t_cgctl_1 #(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16,
    parameter int CW          = 8
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       REQ,
    input  logic       BUSY,
    input  logic       FORCE,
    output logic       ACK,
    output logic       EN,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_WAKE  = 2'b01,
        S_ON    = 2'b10,
        S_DRAIN = 2'b11
    } state_t;

    // A state that must last N cycles loads N-1 and exits when the count hits 0.
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_ack;
    logic          r_en_q;
    logic          r_en;

    logic w_want;
    logic w_idle;
    logic w_cnt_zero;

    assign w_want     = REQ | FORCE;
    assign w_idle     = ~REQ & ~BUSY & ~FORCE;
    assign w_cnt_zero = (r_cnt == '0);

    // State, timer and registered outputs; ACK and en_q track the next state.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_en_q  <= 1'b0;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (w_want) begin
                        r_state <= S_WAKE;
                        r_cnt   <= WAKE_LOAD;
                        r_en_q  <= 1'b1;
                    end
                end
                S_WAKE: begin
                    if (w_cnt_zero) begin
                        r_state <= S_ON;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ON: begin
                    if (w_idle) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= IDLE_LOAD;
                        r_ack   <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // A late request beats expiry, so EN never drops on a re-request.
                    if (w_want) begin
                        r_state <= S_ON;
                        r_ack   <= 1'b1;
                    end else if (BUSY) begin
                        r_cnt <= IDLE_LOAD;
                    end else if (w_cnt_zero) begin
                        r_state <= S_OFF;
                        r_en_q  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_OFF;
                    r_cnt   <= '0;
                    r_ack   <= 1'b0;
                    r_en_q  <= 1'b0;
                end
            endcase
        end
    end

    // Re-time the enable into the CLK-low phase so the and2 output stays clean.
    always_ff @(negedge CLK) begin
        r_en <= r_en_q;
    end

    assign ACK   = r_ack;
    assign EN    = r_en;
    assign STATE = r_state;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_cgctl_1.sv
// Bench for the clock-gate enable controller: directed vector table walking
// reset, wake, drain, BUSY reload, late re-request and reset mid-ON, then a
// random phase checked against a cycle-counting reference model.
module tb_gf180mcu_osu_sc_12t_cgctl_1;

    localparam int WAKE = 2;
    localparam int IDLE = 4;

    logic       CLK;
    logic       RN;
    logic       REQ;
    logic       BUSY;
    logic       FORCE;
    logic       ACK;
    logic       EN;
    logic [1:0] STATE;

    int checks = 0;
    int errors = 0;
    bit en_mon = 0;

    gf180mcu_osu_sc_12t_cgctl_1 #(
        .WAKE_CYCLES(WAKE),
        .IDLE_CYCLES(IDLE),
        .CW(8)
    ) dut (
        .CLK(CLK),
        .RN(RN),
        .REQ(REQ),
        .BUSY(BUSY),
        .FORCE(FORCE),
        .ACK(ACK),
        .EN(EN),
        .STATE(STATE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // EN must only move while CLK is low.
    always @(EN) begin
        if (en_mon) begin
            checks++;
            if (CLK !== 1'b0) begin
                errors++;
                $display("FAIL en_phase: EN changed to %b with CLK=%b, required CLK=0 at %0t", EN, CLK, $time);
            end
        end
    end

    // Reference model: mode 0=OFF 1=WAKE 2=ON 3=DRAIN, with cycles spent in
    // WAKE and consecutive idle cycles in DRAIN counted upward.
    int m_mode = 0;
    int m_age  = 0;
    int m_idle = 0;

    task automatic model_step(input bit rn, input bit req, input bit busy, input bit frc);
        if (!rn) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (req || frc) begin m_mode = 1; m_age = 0; end
                1: begin
                    m_age++;
                    if (m_age >= WAKE) m_mode = 2;
                end
                2: if (!req && !busy && !frc) begin m_mode = 3; m_idle = 0; end
                default: begin
                    if (req || frc) m_mode = 2;
                    else if (busy) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle >= IDLE) m_mode = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic compare(input string name, input logic [1:0] st, input logic ack, input logic en);
        checks++;
        if (STATE !== st || ACK !== ack || EN !== en) begin
            errors++;
            $display("FAIL %s: got state=%0d ack=%b en=%b, required state=%0d ack=%b en=%b",
                     name, STATE, ACK, EN, st, ack, en);
        end
    endtask

    // Drive inputs, take one rising edge, sample outputs after the falling edge.
    task automatic cycle(input bit rn, input bit req, input bit busy, input bit frc);
        RN = rn; REQ = req; BUSY = busy; FORCE = frc;
        @(posedge CLK);
        model_step(rn, req, busy, frc);
        @(negedge CLK);
        #1;
    endtask

    typedef struct {
        bit       rn;
        bit       req;
        bit       busy;
        bit       frc;
        bit [1:0] st;
        bit       ack;
        bit       en;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rn, input bit req, input bit busy, input bit frc,
                       input bit [1:0] st, input bit ack, input bit en);
        vec_t v;
        v.rn = rn; v.req = req; v.busy = busy; v.frc = frc;
        v.st = st; v.ack = ack; v.en = en;
        vecs.push_back(v);
    endtask

    initial begin
        RN = 1'b0; REQ = 1'b0; BUSY = 1'b0; FORCE = 1'b0;

        //   rn req busy frc   state ack en
        add(0, 1, 0, 0,  2'd0, 0, 0);   // reset held with REQ
        add(0, 1, 0, 0,  2'd0, 0, 0);
        add(1, 1, 0, 0,  2'd1, 0, 1);   // release: WAKE, EN up
        add(1, 1, 0, 0,  2'd1, 0, 1);
        add(1, 1, 0, 0,  2'd2, 1, 1);   // ON after WAKE_CYCLES edges
        add(1, 1, 0, 0,  2'd2, 1, 1);
        add(1, 0, 0, 0,  2'd3, 0, 1);   // idle -> DRAIN, ACK drops
        add(1, 0, 0, 0,  2'd3, 0, 1);
        add(1, 0, 0, 0,  2'd3, 0, 1);
        add(1, 0, 0, 0,  2'd3, 0, 1);
        add(1, 0, 0, 0,  2'd0, 0, 0);   // OFF after IDLE_CYCLES edges
        add(1, 0, 1, 0,  2'd0, 0, 0);   // BUSY ignored in OFF
        add(1, 0, 0, 1,  2'd1, 0, 1);   // FORCE wakes
        add(1, 0, 0, 0,  2'd1, 0, 1);   // WAKE runs to completion
        add(1, 0, 0, 0,  2'd2, 1, 1);
        add(1, 0, 0, 1,  2'd2, 1, 1);   // FORCE holds ON
        add(1, 0, 0, 1,  2'd2, 1, 1);
        add(1, 0, 0, 1,  2'd2, 1, 1);
        add(1, 0, 0, 0,  2'd3, 0, 1);   // DRAIN (edge "10")
        add(1, 0, 0, 0,  2'd3, 0, 1);
        add(1, 0, 1, 0,  2'd3, 0, 1);   // BUSY reload (edge "12")
        add(1, 0, 0, 0,  2'd3, 0, 1);
        add(1, 0, 0, 0,  2'd3, 0, 1);
        add(1, 0, 0, 0,  2'd3, 0, 1);   // count at 0 here
        add(1, 0, 1, 0,  2'd3, 0, 1);   // BUSY beats expiry
        add(1, 0, 0, 0,  2'd3, 0, 1);
        add(1, 0, 0, 0,  2'd3, 0, 1);
        add(1, 0, 0, 0,  2'd3, 0, 1);   // count at 0 again
        add(1, 1, 0, 0,  2'd2, 1, 1);   // late re-request wins, EN stays high
        add(1, 0, 0, 0,  2'd3, 0, 1);
        add(1, 1, 0, 0,  2'd2, 1, 1);   // DRAIN -> ON in one edge
        add(1, 0, 1, 0,  2'd2, 1, 1);   // BUSY keeps ON
        add(0, 1, 0, 0,  2'd0, 0, 0);   // reset mid-ON
        add(0, 0, 0, 0,  2'd0, 0, 0);
        add(1, 0, 0, 0,  2'd0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rn, vecs[i].req, vecs[i].busy, vecs[i].frc);
            if (i == 0) en_mon = 1;
            compare($sformatf("vec%0d", i), vecs[i].st, vecs[i].ack, vecs[i].en);
        end

        // Random phase against the reference model.
        for (int n = 0; n < 1500; n++) begin
            bit rn, req, busy, frc;
            rn   = ($urandom_range(0, 79) != 0);
            req  = ($urandom_range(0, 3) == 0);
            busy = ($urandom_range(0, 4) == 0);
            frc  = ($urandom_range(0, 19) == 0);
            cycle(rn, req, busy, frc);
            compare($sformatf("rand%0d", n), 2'(m_mode), (m_mode == 2), (m_mode != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
